lsu_wb: RTL

- Memory-access / write-back stage between execute and the general register file.
- Takes one execute result per handshake.
- ALU results pass straight to write-back.
- Loads and stores run a request/grant/rvalid transaction on the data bus; load data is aligned and sign- or zero-extended.
- Produces the registered write port (rd_en/rd_idx/rd_wdata) the register file consumes.

---
 rtl/lsu_wb_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu_wb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_wb_pkg.sv
// Shared definitions for the load/store write-back stage: widths, register
// x0, memory size codes, FSM encoding, the latched-op record and the
// misalignment rule.
package lsu_wb_pkg;

    localparam int XLEN          = 32;
    localparam int REG_IDX_WIDTH = 5;

    localparam logic [REG_IDX_WIDTH-1:0] REG_X0 = '0;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // What must survive from accept until the bus response returns.
    typedef struct packed {
        logic [1:0]               addr_lo;
        logic [1:0]               size;
        logic                     is_unsigned;
        logic                     rd_en;
        logic [REG_IDX_WIDTH-1:0] rd_idx;
        logic                     we;
    } lsu_op_t;

    // Halves need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_B:   mis = 1'b0;
            MEM_H:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: store byte enables and lane replication,
// load lane extraction with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_wb_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    // Store side: enables follow the addressed lanes, data is replicated so every lane carries it.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (size_i)
            MEM_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then extend from its MSB unless unsigned.
    always_comb begin
        case (addr_lo_i)
            2'd0:    lane_b = rdata_i[7:0];
            2'd1:    lane_b = rdata_i[15:8];
            2'd2:    lane_b = rdata_i[23:16];
            default: lane_b = rdata_i[31:24];
        endcase
        lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sext   = 1'b0;
        case (size_i)
            MEM_B: begin
                sext    = ~unsigned_i & lane_b[7];
                rdata_o = {{(XLEN-8){sext}}, lane_b};
            end
            MEM_H: begin
                sext    = ~unsigned_i & lane_h[15];
                rdata_o = {{(XLEN-16){sext}}, lane_h};
            end
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Memory-access / write-back stage. ALU results go straight to the register
// write port; loads and stores run one req/gnt/rvalid bus transaction at a
// time and block the execute handshake until the response arrives.
module lsu_wb
    import lsu_wb_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REG_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid_i,
    output logic                     ex_ready_o,
    input  logic                     ex_rd_en_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i,
    input  logic [XLEN-1:0]          ex_result_i,
    input  logic                     ex_mem_ren_i,
    input  logic                     ex_mem_wen_i,
    input  logic [1:0]               ex_mem_size_i,
    input  logic                     ex_mem_unsigned_i,
    input  logic [XLEN-1:0]          ex_mem_wdata_i,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic                     mem_we_o,
    output logic [XLEN-1:0]          mem_addr_o,
    output logic [3:0]               mem_be_o,
    output logic [XLEN-1:0]          mem_wdata_o,
    input  logic                     mem_rvalid_i,
    input  logic [XLEN-1:0]          mem_rdata_i,
    output logic                     rd_en_o,
    output logic [REG_IDX_WIDTH-1:0] rd_idx_o,
    output logic [XLEN-1:0]          rd_wdata_o,
    output logic                     misalign_o
);

    lsu_state_e               state_q, state_d;
    lsu_op_t                  op_q, op_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [XLEN-1:0]          mem_addr_q, mem_addr_d;
    logic [3:0]               mem_be_q, mem_be_d;
    logic [XLEN-1:0]          mem_wdata_q, mem_wdata_d;
    logic                     rd_en_q, rd_en_d;
    logic [REG_IDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [XLEN-1:0]          rd_wdata_q, rd_wdata_d;
    logic                     misalign_q, misalign_d;

    logic                     accept;
    logic                     is_mem;
    logic                     misaligned;
    logic [1:0]               al_size;
    logic                     al_unsigned;
    logic [1:0]               al_addr_lo;
    logic [3:0]               al_be;
    logic [XLEN-1:0]          al_wdata;
    logic [XLEN-1:0]          al_rdata;

    assign ex_ready_o = (state_q == ST_IDLE);
    assign accept     = ex_valid_i & ex_ready_o;
    assign is_mem     = ex_mem_ren_i | ex_mem_wen_i;
    assign misaligned = is_misaligned(ex_mem_size_i, ex_result_i[1:0]);

    // One aligner serves both directions: the incoming op while idle, the latched op once in flight.
    always_comb begin
        if (state_q == ST_IDLE) begin
            al_size     = ex_mem_size_i;
            al_unsigned = ex_mem_unsigned_i;
            al_addr_lo  = ex_result_i[1:0];
        end else begin
            al_size     = op_q.size;
            al_unsigned = op_q.is_unsigned;
            al_addr_lo  = op_q.addr_lo;
        end
    end

    lsu_align u_align (
        .size_i     (al_size),
        .unsigned_i (al_unsigned),
        .addr_lo_i  (al_addr_lo),
        .wdata_i    (ex_mem_wdata_i),
        .rdata_i    (mem_rdata_i),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    // Next-state: accept/dispatch in IDLE, hold the bus until granted, then wait for the response.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rd_en_d     = 1'b0;
        rd_idx_d    = rd_idx_q;
        rd_wdata_d  = rd_wdata_q;
        misalign_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        rd_en_d    = ex_rd_en_i & (ex_rd_idx_i != REG_X0);
                        rd_idx_d   = ex_rd_idx_i;
                        rd_wdata_d = ex_result_i;
                    end else if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        op_d.addr_lo     = ex_result_i[1:0];
                        op_d.size        = ex_mem_size_i;
                        op_d.is_unsigned = ex_mem_unsigned_i;
                        op_d.rd_en       = ex_rd_en_i;
                        op_d.rd_idx      = ex_rd_idx_i;
                        op_d.we          = ex_mem_wen_i;
                        mem_req_d        = 1'b1;
                        mem_we_d         = ex_mem_wen_i;
                        mem_addr_d       = {ex_result_i[XLEN-1:2], 2'b00};
                        // Reads present no byte enables and no data.
                        mem_be_d         = ex_mem_wen_i ? al_be : 4'b0000;
                        mem_wdata_d      = ex_mem_wen_i ? al_wdata : '0;
                        state_d          = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = 4'b0000;
                    mem_wdata_d = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    if (!op_q.we) begin
                        rd_en_d    = op_q.rd_en & (op_q.rd_idx != REG_X0);
                        rd_idx_d   = op_q.rd_idx;
                        rd_wdata_d = al_rdata;
                    end
                    op_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rd_en_q     <= 1'b0;
            rd_idx_q    <= '0;
            rd_wdata_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rd_en_q     <= rd_en_d;
            rd_idx_q    <= rd_idx_d;
            rd_wdata_q  <= rd_wdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rd_en_o     = rd_en_q;
    assign rd_idx_o    = rd_idx_q;
    assign rd_wdata_o  = rd_wdata_q;
    assign misalign_o  = misalign_q;

endmodule
